// File: rtl/bnn_tile_accum_binarize.sv
// Purpose: accumulates signed per-neuron partial sums over NUM_TILES tiles, then
//          thresholds each sum (folded batch-norm, optional flip) into one activation bit.
// Latency: out_valid rises the cycle after the last tile's handshake; one tile per cycle sustained.
// Backpressure: one completed result is held; while held, in_ready follows out_ready.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     partial-sum tile handshake (value_in: OUT_DIM x IN_BIT signed)
//   thresh_in, flip_in    per-neuron signed threshold and comparison inversion
//   out_valid/out_ready   result handshake (bits_o, sum_o, sat_o)
module bnn_tile_accum_binarize #(
  parameter int OUT_DIM   = 8,
  parameter int IN_BIT    = 8,
  parameter int ACC_BIT   = 14,
  parameter int NUM_TILES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OUT_DIM*IN_BIT-1:0]  value_in,
  input  logic [OUT_DIM*ACC_BIT-1:0] thresh_in,
  input  logic [OUT_DIM-1:0]         flip_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_DIM-1:0]         bits_o,
  output logic [OUT_DIM*ACC_BIT-1:0] sum_o,
  output logic                       sat_o
);

  localparam int CW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_TILES - 1);
  localparam logic [ACC_BIT-1:0] ACC_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic [ACC_BIT-1:0] ACC_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [ACC_BIT-1:0]        acc_q [OUT_DIM];
  logic [ACC_BIT-1:0]        acc_d [OUT_DIM];
  logic                      sticky_q, sticky_d;
  logic [OUT_DIM-1:0]        bits_q, bits_d;
  logic [OUT_DIM*ACC_BIT-1:0] sum_q, sum_d;
  logic                      sat_q, sat_d;

  logic                      accept;
  logic                      first;
  logic                      last;
  logic                      sticky_nxt;
  logic [ACC_BIT-1:0]        sat_val [OUT_DIM];
  logic [OUT_DIM-1:0]        ovf;
  logic [OUT_DIM-1:0]        ge;

  assign in_ready = (state_q == ACCUM) | out_ready;
  assign accept   = in_valid & in_ready;
  // The count is forced to 0 whenever HOLD is entered, so an accept taken out
  // of HOLD is automatically the first (load) tile of the next layer.
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == LAST_CNT);

  // Per-neuron add with one guard bit; overflow shows as the top two bits differing.
  for (genvar g = 0; g < OUT_DIM; g++) begin : g_elem
    logic [ACC_BIT:0] v_ext;
    logic [ACC_BIT:0] a_ext;
    logic [ACC_BIT:0] wide;

    assign v_ext = {{(ACC_BIT+1-IN_BIT){value_in[g*IN_BIT+IN_BIT-1]}},
                    value_in[g*IN_BIT +: IN_BIT]};
    assign a_ext = {acc_q[g][ACC_BIT-1], acc_q[g]};
    assign wide  = first ? v_ext : (a_ext + v_ext);
    assign ovf[g] = wide[ACC_BIT] ^ wide[ACC_BIT-1];
    assign sat_val[g] = ovf[g] ? (wide[ACC_BIT] ? ACC_MIN : ACC_MAX)
                               : wide[ACC_BIT-1:0];
    assign ge[g] = $signed(sat_val[g]) >= $signed(thresh_in[g*ACC_BIT +: ACC_BIT]);
  end

  // A load restarts the sticky flag for the new layer.
  assign sticky_nxt = (first ? 1'b0 : sticky_q) | (|ovf);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    bits_d   = bits_q;
    sum_d    = sum_q;
    sat_d    = sat_q;

    if (accept) begin
      acc_d    = sat_val;
      sticky_d = sticky_nxt;
      if (last) begin
        state_d = HOLD;
        cnt_d   = '0;
        sat_d   = sticky_nxt;
        bits_d  = ge ^ flip_in;
        for (int i = 0; i < OUT_DIM; i++) begin
          sum_d[i*ACC_BIT +: ACC_BIT] = sat_val[i];
        end
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_q + CW'(1);
      end
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bits_q   <= '0;
      sum_q    <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < OUT_DIM; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bits_q   <= bits_d;
      sum_q    <= sum_d;
      sat_q    <= sat_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign bits_o    = bits_q;
  assign sum_o     = sum_q;
  assign sat_o     = sat_q;

endmodule

// File: doc/bnn_tile_accum_binarize.md
# bnn_tile_accum_binarize

Downstream stage of the XNOR/popcount array: it takes the per-output signed partial sums produced for one input tile, accumulates them over `NUM_TILES` tiles of a layer, and applies a per-output threshold (folded batch-norm) to emit the binarized activation vector for the next layer. It provides valid/ready flow control on both sides and holds one completed result until the consumer accepts it.

## Interface
- `OUT_DIM`, 8, number of output neurons (matches the array's output dimension)
- `IN_BIT`, 8, width of each signed partial sum from the array
- `ACC_BIT`, 14, signed accumulator width, ≥ `IN_BIT`
- `NUM_TILES`, 4, tiles per layer, ≥ 1
- `clk` input 1, single clock, rising edge
- `rst_n` input 1, reset, asynchronous assert, active-low
- `in_valid` input 1, a partial-sum tile is presented
- `in_ready` output 1, the stage accepts the tile this cycle
- `value_in` input `OUT_DIM*IN_BIT`, two's-complement partial sums, element i at `[i*IN_BIT +: IN_BIT]`
- `thresh_in` input `OUT_DIM*ACC_BIT`, signed thresholds; must be stable for a whole layer
- `flip_in` input `OUT_DIM`, per-output comparison inversion (negative BN gamma)
- `out_valid` output 1, a result is held
- `out_ready` input 1, the consumer takes the result
- `bits_o` output `OUT_DIM`, binarized activations; 1 = +1, 0 = −1
- `sum_o` output `OUT_DIM*ACC_BIT`, final accumulated sums
- `sat_o` output 1, at least one accumulator saturated during this layer

## Operation
- States: `ACCUM` (tile count c in 0..NUM_TILES−1) and `HOLD`.
- Reset (`rst_n` low, any cycle, including mid-layer): state `ACCUM`, c=0, all accumulators 0, sticky saturation flag 0, `out_valid`=0, `bits_o`=0, `sum_o`=0, `sat_o`=0. Partial layers are discarded.
- `in_ready` = 1 in `ACCUM`; in `HOLD`, `in_ready` = `out_ready`.
- Each input element is sign-extended to `ACC_BIT + 1` bits and added. A result above 2^(ACC_BIT−1)−1 or below −2^(ACC_BIT−1) is clamped to that bound and sets the sticky flag.
- Accept in `ACCUM` with c=0: acc[i] = sext(value_in[i]). The sticky flag is cleared and then set only if this load saturates, which cannot happen because `ACC_BIT` ≥ `IN_BIT`.
- Accept in `ACCUM` with c>0: acc[i] = sat(acc[i] + sext(value_in[i])).
- Accept with c = NUM_TILES−1 (this includes the first tile when NUM_TILES=1):
  - Compute final sum s[i] including this tile.
  - Register `sum_o`=s, `bits_o[i]` = (s[i] ≥ thresh[i]) XOR flip[i], `sat_o` = sticky flag including this add.
  - Go to `HOLD`, c=0.
- `HOLD`, `out_ready`=0: outputs stay frozen and no input is taken.
- `HOLD`, `out_ready`=1, `in_valid`=0: `out_valid` drops next cycle; go to `ACCUM`.
- `HOLD`, `out_ready`=1, `in_valid`=1: the tile is accepted as the c=0 load of the next layer, going to `ACCUM` with c=1. With NUM_TILES=1 it produces a new result and stays in `HOLD`, so `out_valid` remains 1.
- Comparison is signed full-width. Equality gives 1 before the flip is applied.

## Timing
- All outputs are registered; there is no combinational path from `value_in` to any output.
- `in_ready` depends combinationally only on state and `out_ready`.
- Latency: `out_valid` rises the cycle after the last tile's handshake.
- Throughput: one tile per cycle sustained, including across layer boundaries when `out_ready`=1. A layer therefore takes NUM_TILES cycles.
- While `out_valid`=1 and `out_ready`=0, `bits_o`, `sum_o` and `sat_o` must not change.
- `thresh_in` and `flip_in` are sampled in the last-tile accept cycle.

## Test plan
- Reset/idle:
  - Drive `rst_n`=0 with random inputs → all outputs 0 and `in_ready`=1.
  - Release reset with `in_valid`=0 for 10 cycles → nothing changes.
- Basic layer, OUT_DIM=8, NUM_TILES=4:
  - Stimulus: tiles of element0 = 5, −3, 7, 1; thresh0 = 10; flip0 = 0.
  - Response: `sum_o`[0]=10, `bits_o`[0]=1; `out_valid` one cycle after the 4th accept.
  - With thresh0 = 11 → `bits_o`[0]=0. With flip0 = 1 → `bits_o`[0] is inverted.
- Saturation, ACC_BIT=8, IN_BIT=8:
  - Four tiles of 127 → `sum_o`[0]=127, `sat_o`=1.
  - Four tiles of −128 → `sum_o`[0]=−128, `sat_o`=1.
  - The next layer with small values → `sat_o`=0.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after a result → `in_ready`=0 and outputs stable.
  - Raise `out_ready` while presenting tile 1 of the next layer → that tile is accepted as a load, not added to the old sum. The next result equals the new layer's sum only.
- Streaming, NUM_TILES=1:
  - `in_valid`=`out_ready`=1 for 20 cycles with random data → `out_valid` stays high.
  - Each result matches the previous cycle's tile passed through the threshold compare.
- Reset mid-layer:
  - Assert `rst_n` after 2 of 4 tiles, then run a full layer → the result reflects only the post-reset tiles.
